ezusb_slave_fifo_model: RTL and testbench

Synthesizable responder for the EZ-USB Slave FIFO interface. It emulates the EZ-USB side of the pins: it accepts FPGA writes into an OUT endpoint buffer, serves FPGA reads from an IN endpoint buffer, and generates the delayed EMPTY/FULL flags. A host-side stream port drains committed packets and feeds read data. It is used for loopback bring-up and as the bus partner for the Slave FIFO master in simulation.

---
 rtl/ezusb_slave_fifo_model.sv | 178 +++++++++++++++++
 tb/tb_ezusb_slave_fifo_model.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ezusb_slave_fifo_model.sv
// EZ-USB Slave FIFO pin-level responder: OUT endpoint sink with packet commit,
// IN endpoint source, delayed EMPTY/FULL flags and a host-side stream port.
module ezusb_slave_fifo_model #(
  parameter int OUTEP      = 2,
  parameter int INEP       = 6,
  parameter int DEPTH_LOG2 = 10,
  parameter int PKT_WORDS  = 256,
  parameter int FLAG_DELAY = 2
) (
  input  logic        ifclk,
  input  logic        reset,
  inout  wire  [15:0] fd,
  input  logic        SLWR,
  input  logic        SLRD,
  input  logic        SLOE,
  input  logic        PKTEND,
  input  logic [1:0]  FIFOADDR,
  output logic        EMPTY_FLAG,
  output logic        FULL_FLAG,
  output logic [15:0] host_do,
  output logic        host_do_valid,
  output logic        host_do_last,
  input  logic        host_do_ready,
  input  logic [15:0] host_di,
  input  logic        host_di_valid,
  output logic        host_di_ready,
  output logic [15:0] ovf_cnt,
  output logic [15:0] unf_cnt
);
  localparam int DEPTH    = 1 << DEPTH_LOG2;
  localparam int CQ_LOG2  = 4;
  localparam int CQ_DEPTH = 1 << CQ_LOG2;
  localparam int LEN_W    = $clog2(PKT_WORDS + 1);
  localparam logic [1:0] OUT_ADDR = 2'(OUTEP / 2 - 1);
  localparam logic [1:0] IN_ADDR  = 2'(INEP / 2 - 1);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   occ_t;
  typedef logic [LEN_W-1:0]      len_t;
  typedef logic [CQ_LOG2-1:0]    cq_ptr_t;
  typedef logic [CQ_LOG2:0]      cq_occ_t;

  logic [15:0] out_mem [DEPTH];
  logic [15:0] in_mem  [DEPTH];
  len_t        cq_mem  [CQ_DEPTH];

  ptr_t    out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  ptr_t    in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  occ_t    out_cnt_q, out_cnt_d, in_cnt_q, in_cnt_d;
  len_t    pkt_cnt_q, pkt_cnt_d, head_idx_q, head_idx_d;
  cq_ptr_t cq_wr_q, cq_wr_d, cq_rd_q, cq_rd_d;
  cq_occ_t cq_cnt_q, cq_cnt_d;
  logic [15:0] ovf_q, ovf_d, unf_q, unf_d;
  logic [FLAG_DELAY-1:0] full_pipe_q, empty_pipe_q;
  logic [FLAG_DELAY:0]   full_shift, empty_shift;

  logic out_sel, in_sel, collide, wr_req, rd_req;
  logic raw_full_n, raw_empty_n, wr_ok, commit, commit_ok;
  logic drain, pkt_done, in_full, in_push, in_pop, fd_oe;
  len_t pkt_next, head_len;
  logic [15:0] fd_out;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign out_sel = (FIFOADDR == OUT_ADDR);
  assign in_sel  = (FIFOADDR == IN_ADDR);
  assign collide = !SLWR && !SLRD;
  assign wr_req  = !SLWR && SLRD && SLOE && out_sel;
  assign rd_req  = !SLRD && SLWR && !SLOE && in_sel;

  // A full commit-length queue blocks writes exactly like a full data buffer.
  assign raw_full_n  = (out_cnt_q != occ_t'(DEPTH)) && (cq_cnt_q != cq_occ_t'(CQ_DEPTH));
  assign raw_empty_n = (in_cnt_q != '0);
  assign wr_ok       = wr_req && raw_full_n;
  assign pkt_next    = pkt_cnt_q + len_t'(wr_ok);
  assign commit      = (pkt_next == len_t'(PKT_WORDS)) || (!PKTEND && out_sel && pkt_next != '0);
  assign commit_ok   = commit && (cq_cnt_q != cq_occ_t'(CQ_DEPTH));

  assign head_len      = cq_mem[cq_rd_q];
  assign host_do       = out_mem[out_rd_q];
  assign host_do_valid = (cq_cnt_q != '0);
  assign host_do_last  = host_do_valid && (head_idx_q == head_len - len_t'(1));
  assign drain         = host_do_valid && host_do_ready;
  assign pkt_done      = drain && host_do_last;

  assign in_full       = (in_cnt_q == occ_t'(DEPTH));
  assign host_di_ready = !reset && !in_full;
  assign in_push       = host_di_valid && host_di_ready;
  assign in_pop        = rd_req && raw_empty_n;

  assign fd_oe  = !SLOE && in_sel;
  assign fd_out = raw_empty_n ? in_mem[in_rd_q] : 16'h0000;
  assign fd     = fd_oe ? fd_out : 16'hzzzz;

  assign full_shift  = {full_pipe_q, raw_full_n};
  assign empty_shift = {empty_pipe_q, raw_empty_n};
  assign FULL_FLAG   = full_pipe_q[FLAG_DELAY-1];
  assign EMPTY_FLAG  = empty_pipe_q[FLAG_DELAY-1];
  assign ovf_cnt     = ovf_q;
  assign unf_cnt     = unf_q;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path infers a latch.
    out_wr_d   = out_wr_q + ptr_t'(wr_ok);
    out_rd_d   = out_rd_q + ptr_t'(drain);
    in_wr_d    = in_wr_q + ptr_t'(in_push);
    in_rd_d    = in_rd_q + ptr_t'(in_pop);
    cq_wr_d    = cq_wr_q + cq_ptr_t'(commit_ok);
    cq_rd_d    = cq_rd_q + cq_ptr_t'(pkt_done);
    pkt_cnt_d  = commit_ok ? '0 : pkt_next;
    head_idx_d = head_idx_q;
    out_cnt_d  = out_cnt_q;
    in_cnt_d   = in_cnt_q;
    cq_cnt_d   = cq_cnt_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;

    if (drain) head_idx_d = host_do_last ? '0 : head_idx_q + len_t'(1);

    if (wr_ok && !drain)      out_cnt_d = out_cnt_q + occ_t'(1);
    else if (!wr_ok && drain) out_cnt_d = out_cnt_q - occ_t'(1);

    if (in_push && !in_pop)      in_cnt_d = in_cnt_q + occ_t'(1);
    else if (!in_push && in_pop) in_cnt_d = in_cnt_q - occ_t'(1);

    if (commit_ok && !pkt_done)      cq_cnt_d = cq_cnt_q + cq_occ_t'(1);
    else if (!commit_ok && pkt_done) cq_cnt_d = cq_cnt_q - cq_occ_t'(1);

    if (wr_req && !raw_full_n)             ovf_d = sat_inc(ovf_q);
    if (collide || (rd_req && !raw_empty_n)) unf_d = sat_inc(unf_q);
  end

  // NOTE: storage arrays carry no reset; the pointers and counts decide what is valid.
  always_ff @(posedge ifclk) begin
    if (wr_ok)     out_mem[out_wr_q] <= fd;
    if (commit_ok) cq_mem[cq_wr_q]   <= pkt_next;
    if (in_push)   in_mem[in_wr_q]   <= host_di;
  end

  // NOTE: state registers use non-blocking assignment so all of them update together.
  always_ff @(posedge ifclk) begin
    if (reset) begin
      out_wr_q     <= '0;
      out_rd_q     <= '0;
      in_wr_q      <= '0;
      in_rd_q      <= '0;
      out_cnt_q    <= '0;
      in_cnt_q     <= '0;
      pkt_cnt_q    <= '0;
      head_idx_q   <= '0;
      cq_wr_q      <= '0;
      cq_rd_q      <= '0;
      cq_cnt_q     <= '0;
      ovf_q        <= '0;
      unf_q        <= '0;
      full_pipe_q  <= '1;
      empty_pipe_q <= '0;
    end else begin
      out_wr_q     <= out_wr_d;
      out_rd_q     <= out_rd_d;
      in_wr_q      <= in_wr_d;
      in_rd_q      <= in_rd_d;
      out_cnt_q    <= out_cnt_d;
      in_cnt_q     <= in_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      head_idx_q   <= head_idx_d;
      cq_wr_q      <= cq_wr_d;
      cq_rd_q      <= cq_rd_d;
      cq_cnt_q     <= cq_cnt_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      full_pipe_q  <= full_shift[FLAG_DELAY-1:0];
      empty_pipe_q <= empty_shift[FLAG_DELAY-1:0];
    end
  end
endmodule

// File: tb/tb_ezusb_slave_fifo_model.sv
// Bench for ezusb_slave_fifo_model: directed scenarios plus random traffic,
// all checked against a queue-based model of the endpoint behaviour.
module tb_ezusb_slave_fifo_model;
  localparam int DEPTH      = 1024;
  localparam int PKT_WORDS  = 256;
  localparam int FLAG_DELAY = 2;
  localparam int CQ_DEPTH   = 16;
  localparam logic [1:0] OUT_ADDR = 2'd0;
  localparam logic [1:0] IN_ADDR  = 2'd2;

  logic        ifclk = 1'b0;
  logic        reset, slwr, slrd, sloe, pktend;
  logic [1:0]  fifoaddr;
  logic [15:0] fd_drv;
  wire  [15:0] fd;
  logic        empty_flag, full_flag;
  logic [15:0] host_do;
  logic        host_do_valid, host_do_last, host_do_ready;
  logic [15:0] host_di;
  logic        host_di_valid, host_di_ready;
  logic [15:0] ovf_cnt, unf_cnt;

  // The bench owns the bus whenever SLOE is high; the DUT may drive only when it is low.
  assign fd = sloe ? fd_drv : 16'hzzzz;

  ezusb_slave_fifo_model #(
    .OUTEP(2), .INEP(6), .DEPTH_LOG2(10), .PKT_WORDS(PKT_WORDS), .FLAG_DELAY(FLAG_DELAY)
  ) dut (
    .ifclk(ifclk), .reset(reset), .fd(fd),
    .SLWR(slwr), .SLRD(slrd), .SLOE(sloe), .PKTEND(pktend), .FIFOADDR(fifoaddr),
    .EMPTY_FLAG(empty_flag), .FULL_FLAG(full_flag),
    .host_do(host_do), .host_do_valid(host_do_valid), .host_do_last(host_do_last),
    .host_do_ready(host_do_ready), .host_di(host_di), .host_di_valid(host_di_valid),
    .host_di_ready(host_di_ready), .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
  );

  always #5 ifclk = ~ifclk;

  int errors = 0;
  int checks = 0;

  logic [16:0] exp_host[$];
  logic [15:0] cur_pkt[$];
  logic [15:0] in_q[$];
  logic [16:0] seen[$];
  bit          full_hist[$];
  bit          empty_hist[$];
  int          n_commits, m_ovf, m_unf;
  bit          model_ok = 1'b0;

  task automatic set_idle();
    slwr = 1'b1; slrd = 1'b1; sloe = 1'b1; pktend = 1'b1;
    fifoaddr = OUT_ADDR; host_di_valid = 1'b0;
  endtask

  // One clock: compare against the model, advance the model, then cross the edge.
  task automatic tick();
    bit room, in_empty, in_full, out_sel, in_sel, wr_req, rd_req, coll, valid, ef, ff;
    logic [16:0] w;
    int nc;
    #1;
    out_sel = (fifoaddr == OUT_ADDR);
    in_sel  = (fifoaddr == IN_ADDR);
    valid   = (exp_host.size() > 0);
    if (model_ok) begin
      checks++;
      if (host_do_valid !== valid) begin
        errors++; $display("FAIL host_do_valid: got %b want %b at %0t", host_do_valid, valid, $time);
      end
      if (valid) begin
        checks++;
        if ({host_do_last, host_do} !== exp_host[0]) begin
          errors++; $display("FAIL host_do: got last=%b %h want %h at %0t", host_do_last, host_do, exp_host[0], $time);
        end
      end
      if (!sloe && in_sel) begin
        checks++;
        if (fd !== ((in_q.size() > 0) ? in_q[0] : 16'h0000)) begin
          errors++; $display("FAIL fd_read: got %h want %h at %0t", fd, (in_q.size() > 0) ? in_q[0] : 16'h0000, $time);
        end
      end
      checks++;
      if (host_di_ready !== (!reset && in_q.size() < DEPTH)) begin
        errors++; $display("FAIL host_di_ready: got %b at %0t", host_di_ready, $time);
      end
    end
    if (reset) begin
      exp_host.delete(); cur_pkt.delete(); in_q.delete();
      full_hist.delete(); empty_hist.delete();
      n_commits = 0; m_ovf = 0; m_unf = 0;
    end else begin
      room     = (exp_host.size() + cur_pkt.size() < DEPTH) && (n_commits < CQ_DEPTH);
      nc       = n_commits;
      in_empty = (in_q.size() == 0);
      in_full  = (in_q.size() >= DEPTH);
      wr_req   = !slwr && slrd && sloe && out_sel;
      rd_req   = !slrd && slwr && !sloe && in_sel;
      coll     = !slwr && !slrd;
      if (valid && host_do_ready) begin
        if (exp_host[0][16]) n_commits--;
        void'(exp_host.pop_front());
      end
      if (wr_req) begin
        if (room) cur_pkt.push_back(fd_drv);
        else if (m_ovf < 65535) m_ovf++;
      end
      if (nc < CQ_DEPTH && (cur_pkt.size() == PKT_WORDS || (!pktend && out_sel && cur_pkt.size() > 0))) begin
        foreach (cur_pkt[i]) begin
          w = {1'b0, cur_pkt[i]};
          w[16] = (i == cur_pkt.size() - 1);
          exp_host.push_back(w);
        end
        cur_pkt.delete();
        n_commits++;
      end
      if (rd_req) begin
        if (!in_empty) void'(in_q.pop_front());
        else if (m_unf < 65535) m_unf++;
      end
      if (coll && m_unf < 65535) m_unf++;
      if (host_di_valid && !in_full) in_q.push_back(host_di);
      full_hist.push_back((exp_host.size() + cur_pkt.size() < DEPTH) && (n_commits < CQ_DEPTH));
      empty_hist.push_back(in_q.size() > 0);
      while (full_hist.size() > FLAG_DELAY + 1) void'(full_hist.pop_front());
      while (empty_hist.size() > FLAG_DELAY + 1) void'(empty_hist.pop_front());
    end
    @(posedge ifclk);
    #1;
    if (reset) model_ok = 1'b1;
    if (model_ok) begin
      ff = (full_hist.size() > FLAG_DELAY) ? full_hist[full_hist.size() - 1 - FLAG_DELAY] : 1'b1;
      ef = (empty_hist.size() > FLAG_DELAY) ? empty_hist[empty_hist.size() - 1 - FLAG_DELAY] : 1'b0;
      checks++;
      if (full_flag !== ff) begin
        errors++; $display("FAIL FULL_FLAG: got %b want %b at %0t", full_flag, ff, $time);
      end
      checks++;
      if (empty_flag !== ef) begin
        errors++; $display("FAIL EMPTY_FLAG: got %b want %b at %0t", empty_flag, ef, $time);
      end
      checks++;
      if (ovf_cnt !== 16'(m_ovf) || unf_cnt !== 16'(m_unf)) begin
        errors++; $display("FAIL counters: got ovf=%0d unf=%0d want ovf=%0d unf=%0d", ovf_cnt, unf_cnt, m_ovf, m_unf);
      end
    end
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_word(input logic [15:0] data, input logic commit_now);
    fifoaddr = OUT_ADDR; sloe = 1'b1; slrd = 1'b1; slwr = 1'b0;
    fd_drv = data; pktend = !commit_now;
    tick();
    slwr = 1'b1; pktend = 1'b1;
  endtask

  task automatic drain_words(input int n, input int budget);
    seen.delete();
    host_do_ready = 1'b1;
    for (int c = 0; c < budget && seen.size() < n; c++) begin
      #1;
      if (host_do_valid) seen.push_back({host_do_last, host_do});
      tick();
    end
    checks++;
    if (seen.size() != n) begin
      errors++; $display("FAIL drain_count: got %0d words want %0d", seen.size(), n);
    end
  endtask

  task automatic test_reset();
    set_idle();
    host_do_ready = 1'b0; fd_drv = '0; host_di = '0;
    reset = 1'b1;
    tick();
    checks++;
    if (host_di_ready !== 1'b0 || host_do_valid !== 1'b0 || host_do_last !== 1'b0) begin
      errors++; $display("FAIL reset_stream: got di_ready=%b do_valid=%b do_last=%b want 0 0 0", host_di_ready, host_do_valid, host_do_last);
    end
    checks++;
    if (empty_flag !== 1'b0 || full_flag !== 1'b1) begin
      errors++; $display("FAIL reset_flags: got EMPTY=%b FULL=%b want 0 1", empty_flag, full_flag);
    end
    checks++;
    if (ovf_cnt !== 16'd0 || unf_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_counters: got %0d %0d want 0 0", ovf_cnt, unf_cnt);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_full_packet();
    int bad, n_last;
    do_reset();
    host_do_ready = 1'b1;
    for (int i = 0; i < PKT_WORDS; i++) write_word(16'(i), 1'b0);
    set_idle();
    drain_words(PKT_WORDS, 2 * PKT_WORDS);
    bad = 0; n_last = 0;
    foreach (seen[i]) begin
      if (seen[i][15:0] !== 16'(i)) bad++;
      if (seen[i][16]) n_last++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL full_pkt_data: got %0d wrong words want 0", bad); end
    checks++;
    if (n_last != 1 || seen.size() != PKT_WORDS || seen[PKT_WORDS-1][16] !== 1'b1) begin
      errors++; $display("FAIL full_pkt_last: got %0d last flags want 1 on word %0d", n_last, PKT_WORDS - 1);
    end
    checks++;
    if (ovf_cnt !== 16'd0) begin errors++; $display("FAIL full_pkt_ovf: got %0d want 0", ovf_cnt); end
  endtask

  task automatic test_short_packet();
    int bad, extra;
    do_reset();
    host_do_ready = 1'b1;
    for (int i = 0; i < 5; i++) write_word(16'h5000 + 16'(i), i == 4);
    set_idle();
    drain_words(5, 40);
    bad = 0;
    foreach (seen[i]) if (seen[i] !== {1'(i == 4), 16'h5000 + 16'(i)}) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL short_pkt_words: got %0d wrong want 0", bad); end
    fifoaddr = OUT_ADDR; pktend = 1'b0;
    tick();
    set_idle();
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (host_do_valid) extra++;
      tick();
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL empty_pktend: got %0d valid cycles want 0", extra); end
  endtask

  task automatic test_overflow();
    int bad;
    do_reset();
    host_do_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) write_word(16'(i * 7 + 3), 1'b0);
    checks++;
    if (full_flag !== 1'b1) begin errors++; $display("FAIL full_early: got %b want 1", full_flag); end
    for (int k = 1; k <= 3; k++) begin
      write_word(16'hBAD0 + 16'(k), 1'b0);
      checks++;
      if (full_flag !== ((k < FLAG_DELAY) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL full_delay: got %b at +%0d want %b", full_flag, k, (k < FLAG_DELAY));
      end
    end
    set_idle();
    checks++;
    if (ovf_cnt !== 16'd3) begin errors++; $display("FAIL ovf_cnt: got %0d want 3", ovf_cnt); end
    drain_words(DEPTH, DEPTH + 200);
    bad = 0;
    foreach (seen[i]) if (seen[i] !== {1'((i % PKT_WORDS) == PKT_WORDS - 1), 16'(i * 7 + 3)}) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ovf_drain_data: got %0d corrupted want 0", bad); end
    for (int c = 0; c < FLAG_DELAY + 1; c++) tick();
    checks++;
    if (full_flag !== 1'b1) begin errors++; $display("FAIL full_recover: got %b want 1", full_flag); end
  endtask

  task automatic test_in_read();
    logic [15:0] vals [4];
    do_reset();
    for (int i = 0; i < 3; i++) vals[i] = 16'($urandom_range(1, 65535));
    vals[3] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      host_di = vals[i]; host_di_valid = 1'b1;
      tick();
    end
    host_di_valid = 1'b0;
    for (int c = 0; c < FLAG_DELAY + 1; c++) tick();
    checks++;
    if (empty_flag !== 1'b1) begin errors++; $display("FAIL empty_rise: got %b want 1", empty_flag); end
    fifoaddr = IN_ADDR; sloe = 1'b0; slrd = 1'b0;
    for (int r = 0; r < 4; r++) begin
      #1;
      checks++;
      if (fd !== vals[r]) begin errors++; $display("FAIL fd_seq: got %h at read %0d want %h", fd, r, vals[r]); end
      tick();
      if (r >= 2) begin
        checks++;
        if (empty_flag !== (((r - 2) < FLAG_DELAY) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL empty_delay: got %b at +%0d", empty_flag, r - 2);
        end
      end
    end
    slrd = 1'b1;
    for (int k = 2; k <= FLAG_DELAY + 1; k++) begin
      tick();
      checks++;
      if (empty_flag !== ((k < FLAG_DELAY) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL empty_delay: got %b at +%0d", empty_flag, k);
      end
    end
    checks++;
    if (unf_cnt !== 16'd1) begin errors++; $display("FAIL unf_read_empty: got %0d want 1", unf_cnt); end
    set_idle();
  endtask

  task automatic test_collision();
    logic [15:0] x;
    int extra;
    do_reset();
    x = 16'($urandom_range(1, 65535));
    host_di = x; host_di_valid = 1'b1;
    tick();
    host_di_valid = 1'b0;
    fifoaddr = OUT_ADDR; sloe = 1'b1; fd_drv = 16'hDEAD; slwr = 1'b0; slrd = 1'b0;
    tick();
    set_idle();
    checks++;
    if (unf_cnt !== 16'd1) begin errors++; $display("FAIL collide_out_unf: got %0d want 1", unf_cnt); end
    pktend = 1'b0;
    tick();
    set_idle();
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (host_do_valid) extra++;
      tick();
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL collide_no_write: got %0d valid cycles want 0", extra); end
    fifoaddr = IN_ADDR; sloe = 1'b0; slwr = 1'b0; slrd = 1'b0;
    tick();
    slwr = 1'b1; slrd = 1'b1;
    #1;
    checks++;
    if (fd !== x) begin errors++; $display("FAIL collide_no_pop: got %h want %h", fd, x); end
    checks++;
    if (unf_cnt !== 16'd2) begin errors++; $display("FAIL collide_in_unf: got %0d want 2", unf_cnt); end
    set_idle();
  endtask

  task automatic test_reset_mid();
    int bad, stray;
    do_reset();
    host_do_ready = 1'b0;
    for (int i = 0; i < 100; i++) write_word(16'($urandom), 1'b0);
    set_idle();
    for (int i = 0; i < 10; i++) begin
      host_di = 16'($urandom); host_di_valid = 1'b1;
      tick();
    end
    host_di_valid = 1'b0;
    for (int c = 0; c < FLAG_DELAY + 1; c++) tick();
    checks++;
    if (empty_flag !== 1'b1 || host_do_valid !== 1'b0) begin
      errors++; $display("FAIL pre_reset_state: got EMPTY=%b valid=%b want 1 0", empty_flag, host_do_valid);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({empty_flag, full_flag, host_do_valid, host_do_last, host_di_ready} !== 5'b01000 ||
        ovf_cnt !== 16'd0 || unf_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_reset_outputs: got E=%b F=%b v=%b l=%b r=%b ovf=%0d unf=%0d",
                         empty_flag, full_flag, host_do_valid, host_do_last, host_di_ready, ovf_cnt, unf_cnt);
    end
    tick();
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < FLAG_DELAY + 2; c++) begin
      tick();
      if (empty_flag !== 1'b0 || host_do_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL post_reset_flush: got %0d stray cycles want 0", stray); end
    for (int i = 0; i < 8; i++) write_word(16'hC000 + 16'(i), i == 7);
    set_idle();
    drain_words(8, 40);
    bad = 0;
    foreach (seen[i]) if (seen[i] !== {1'(i == 7), 16'hC000 + 16'(i)}) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL post_reset_packet: got %0d wrong words want 0", bad); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      fifoaddr      = ($urandom_range(0, 9) < 5) ? OUT_ADDR : (($urandom_range(0, 9) < 8) ? IN_ADDR : 2'd1);
      sloe          = $urandom_range(0, 1);
      slwr          = ($urandom_range(0, 9) >= 4);
      slrd          = ($urandom_range(0, 9) >= 4);
      pktend        = ($urandom_range(0, 19) != 0);
      fd_drv        = 16'($urandom);
      host_do_ready = $urandom_range(0, 1);
      host_di_valid = ($urandom_range(0, 9) < 4);
      host_di       = 16'($urandom);
      tick();
    end
    set_idle();
    host_do_ready = 1'b1;
    for (int c = 0; c < DEPTH + 100; c++) tick();
    checks++;
    if (host_do_valid !== 1'b0) begin errors++; $display("FAIL random_drain: got valid=%b want 0", host_do_valid); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_packet();
    test_short_packet();
    test_overflow();
    test_in_read();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
